z16_decode_stage: RTL and testbench
===================================

Z16_DECODE_STAGE -- requirements
Module: z16_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 16, immediate/datapath width, legal range 16..64.
REQ-002 SHALL have parameter SB_CNT_W, default 2, width of each per-register pending-write counter, legal range 1..4.
REQ-003 SHALL have i_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_instr  in  16  instruction word; i_valid  in  1  instruction present; o_ready  out  1  stage accepts.
REQ-006 SHALL have o_valid  out  1  decoded bundle present; i_ready  in  1  downstream accepts.
REQ-007 SHALL have o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr  out  4 each; o_imm  out  XLEN; o_rd_wen, o_mem_wen  out  1; o_alu_ctrl  out  4.
REQ-008 SHALL have i_wb_valid  in  1  and i_wb_addr  in  4  register write retired; i_flush  in  1  discard held bundle.

Function
REQ-009 Decode: opcode=instr[3:0]; rd=instr[7:4]; rs2=instr[15:12]; rs1=instr[7:4] for opcode 9, else instr[11:8].
REQ-010 Immediate, sign-extended to XLEN: op 9 -> instr[15:8]; op A -> instr[15:12]; op B -> instr[7:4]; others -> 0.
REQ-011 rd_wen=1 for opcode <= A; mem_wen=1 only for opcode B; alu_ctrl=opcode for opcode <= 8, else 0.
REQ-012 Source use: ops 0-8, B-F read rs1 and rs2; op 9 reads rs1; op A reads rs1.
REQ-013 Accept = i_valid && o_ready; accepted bundle appears in output register next cycle (latency 1).
REQ-014 o_ready = (!o_valid || i_ready) && !hazard && !i_flush; o_ready may depend combinationally on i_instr.
REQ-015 hazard = any used source has nonzero counter, or rd_wen and counter[rd] is at all-ones (saturation).
REQ-016 Counters use registered values only; a same-cycle writeback does not clear a hazard until the next cycle.
REQ-017 Accepting an rd_wen instruction increments counter[rd]; i_wb_valid decrements counter[i_wb_addr]; both on same register same cycle -> unchanged.
REQ-018 Writeback to a register whose counter is 0 SHALL leave it 0 (no underflow).
REQ-019 Output register holds contents stable while o_valid && !i_ready; clears o_valid when consumed and no new accept.
REQ-020 i_flush: o_valid->0 next cycle; if held bundle had rd_wen, its counter[rd] is decremented, combined with any same-cycle writeback (net -2 on same register floored at 0).
REQ-021 Register 0 is not special; it is tracked like all others.

Reset
REQ-022 On i_rst: o_valid=0, all decoded outputs 0, all counters 0, immediately and asynchronously.
REQ-023 o_ready after reset deassertion equals REQ-014 evaluated with empty state.
REQ-024 Reset mid-stall discards the held bundle and all pending-write state; no writebacks are expected afterwards.

Configuration
REQ-025 Macro Z16_DECODE_SCOREBOARD_EN defined: counters and hazard logic per REQ-015..REQ-020 present.
REQ-026 Macro undefined: no counters, hazard=0 permanently, i_wb_* ignored, flush only clears o_valid.

Structure
REQ-027 Shared package z16_pkg SHALL hold opcode constants (OP_LI=9, OP_LD=A, OP_ST=B), the 4-bit register-address width, and the decoded-bundle struct.
REQ-028 Combinational field decode SHALL be a sub-module z16_decode_fields; this module adds handshake, output register and scoreboard.

Verification
REQ-029 Reset then instr 16'hF539 (op 9, rd 3, imm 8'hF5), i_ready=1 -> next cycle o_valid=1, o_imm=16'hFFF5, o_rs1_addr=3, o_rd_wen=1.
REQ-030 Accept op 1 rd=2, then op 2 with rs1=2 -> o_ready=0 until i_wb_valid addr 2 asserted; o_ready=1 the cycle after writeback.
REQ-031 SB_CNT_W=1: two consecutive rd=5 writers with no writeback -> second stalls; writeback on addr 5 while a third rd=5 writer is accepted -> counter stays 1.
REQ-032 i_ready=0 for 4 cycles with o_valid=1 -> all outputs stable; then i_ready=1 with new valid input -> back-to-back bundles, no bubble.
REQ-033 Held op-3 bundle rd=7, i_flush=1 -> o_valid=0 next cycle, counter[7] back to 0, dependent instr reading r7 accepted immediately.
REQ-034 Build without Z16_DECODE_SCOREBOARD_EN: REQ-030 stimulus -> no stall, o_ready follows only downstream readiness.

Source files
------------

// File: rtl/z16_pkg.sv
// z16_pkg: definitions shared by the Z16 decode stage.
//   - Opcode constants for the opcodes the decoder treats specially
//     (OP_LI load-immediate, OP_LD load, OP_ST store).
//   - Register-address width and register count.
//   - bundle_t: the decoded instruction bundle carried from field
//     decode into the stage's output register. The immediate is held
//     as an 8-bit sign-extended value so the struct is independent of
//     XLEN. The stage widens it to XLEN on output.
package z16_pkg;

    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [3:0] OP_LI = 4'h9;
    localparam logic [3:0] OP_LD = 4'hA;
    localparam logic [3:0] OP_ST = 4'hB;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [7:0]        imm8;     // already sign-extended to 8 bits
        logic              rd_wen;
        logic              mem_wen;
        logic [3:0]        alu_ctrl;
        logic              use_rs1;
        logic              use_rs2;
    } bundle_t;

endpackage

// File: rtl/z16_decode_fields.sv
// z16_decode_fields: purely combinational field decode of one 16-bit
// Z16 instruction into a bundle_t.
// Ports:
//   instr  in  16        raw instruction word
//   fields out bundle_t  decoded opcode, register addresses, immediate,
//                        control bits and source-use flags
module z16_decode_fields
    import z16_pkg::*;
(
    input  logic [15:0] instr,
    output bundle_t     fields
);

    logic [3:0] op;
    assign op = instr[3:0];

    always_comb begin
        fields          = '0;
        fields.opcode   = op;
        fields.rd       = instr[7:4];
        fields.rs2      = instr[15:12];
        // Load-immediate has no room for rs1 in the high bits, so it
        // reads its own destination field instead.
        fields.rs1      = (op == OP_LI) ? instr[7:4] : instr[11:8];

        case (op)
            OP_LI:   fields.imm8 = instr[15:8];
            OP_LD:   fields.imm8 = {{4{instr[15]}}, instr[15:12]};
            OP_ST:   fields.imm8 = {{4{instr[7]}}, instr[7:4]};
            default: fields.imm8 = 8'h00;
        endcase

        fields.rd_wen   = (op <= OP_LD);
        fields.mem_wen  = (op == OP_ST);
        fields.alu_ctrl = (op <= 4'h8) ? op : 4'h0;
        fields.use_rs1  = 1'b1;
        // LI and LD carry an immediate where rs2 would be.
        fields.use_rs2  = (op != OP_LI) && (op != OP_LD);
    end

endmodule

// File: rtl/z16_decode_stage.sv
// z16_decode_stage: Z16 decode pipeline stage. Decodes the incoming
// instruction, holds it in a single output register under a
// valid/ready handshake and, optionally, tracks pending register writes
// to stall on RAW hazards.
//
// Build option: define Z16_DECODE_SCOREBOARD_EN to include the
// per-register pending-write counters and hazard stall. Without it the
// stage never stalls on hazards and ignores i_wb_*.
//
// Ports:
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_instr, i_valid, o_ready  upstream instruction handshake
//   o_valid, i_ready         downstream bundle handshake
//   o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm,
//   o_rd_wen, o_mem_wen, o_alu_ctrl   registered decoded bundle
//   i_wb_valid, i_wb_addr    a register write has retired
//   i_flush                  discard the held bundle
module z16_decode_stage
    import z16_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int SB_CNT_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_instr,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [3:0]        o_opcode,
    output logic [3:0]        o_rd_addr,
    output logic [3:0]        o_rs1_addr,
    output logic [3:0]        o_rs2_addr,
    output logic [XLEN-1:0]   o_imm,
    output logic              o_rd_wen,
    output logic              o_mem_wen,
    output logic [3:0]        o_alu_ctrl,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic              i_flush
);

    bundle_t dec;
    bundle_t held_reg;
    logic    valid_reg;
    logic    hazard;
    logic    accept;

    z16_decode_fields u_fields (
        .instr  (i_instr),
        .fields (dec)
    );

    assign o_ready = (!valid_reg || i_ready) && !hazard && !i_flush;
    assign accept  = i_valid && o_ready;

    // Output register. Flush wins; accept can never coincide with it
    // because o_ready is low during a flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_reg <= 1'b0;
            held_reg  <= '0;
        end else if (i_flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            held_reg  <= dec;
        end else if (i_ready) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef Z16_DECODE_SCOREBOARD_EN
    logic [SB_CNT_W-1:0] cnt_reg [NUM_REGS];

    // Hazard looks only at registered counts, so a writeback in this
    // cycle releases the stall one cycle later.
    assign hazard = (dec.use_rs1 && (cnt_reg[dec.rs1] != '0))
                 || (dec.use_rs2 && (cnt_reg[dec.rs2] != '0))
                 || (dec.rd_wen  && (&cnt_reg[dec.rd]));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            logic                inc;
            logic                wb_dec;
            logic                fl_dec;
            logic [SB_CNT_W:0]   up;
            logic [SB_CNT_W:0]   down;
            logic [SB_CNT_W-1:0] cnt_next;

            assign inc    = accept && dec.rd_wen && (dec.rd == REG_AW'(gi));
            assign wb_dec = i_wb_valid && (i_wb_addr == REG_AW'(gi));
            // A flushed writer will never retire, so drop its claim.
            assign fl_dec = i_flush && valid_reg && held_reg.rd_wen
                         && (held_reg.rd == REG_AW'(gi));

            // One extra bit of headroom: up never exceeds the saturated
            // count (inc is blocked at saturation) and down is at most 2.
            assign up       = {1'b0, cnt_reg[gi]} + (SB_CNT_W+1)'(inc);
            assign down     = (SB_CNT_W+1)'(wb_dec) + (SB_CNT_W+1)'(fl_dec);
            assign cnt_next = (up >= down) ? SB_CNT_W'(up - down) : '0;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) cnt_reg[gi] <= '0;
                else       cnt_reg[gi] <= cnt_next;
            end
        end
    endgenerate
`else
    assign hazard = 1'b0;
    logic unused_wb;
    assign unused_wb = &{1'b0, i_wb_valid, i_wb_addr};
`endif

    logic unused_use;
    assign unused_use = &{1'b0, held_reg.use_rs1, held_reg.use_rs2};

    assign o_valid    = valid_reg;
    assign o_opcode   = held_reg.opcode;
    assign o_rd_addr  = held_reg.rd;
    assign o_rs1_addr = held_reg.rs1;
    assign o_rs2_addr = held_reg.rs2;
    assign o_imm      = {{(XLEN-8){held_reg.imm8[7]}}, held_reg.imm8};
    assign o_rd_wen   = held_reg.rd_wen;
    assign o_mem_wen  = held_reg.mem_wen;
    assign o_alu_ctrl = held_reg.alu_ctrl;

endmodule

// File: tb/tb_z16_decode_stage.sv
// tb_z16_decode_stage: self-checking bench for z16_decode_stage.
// Table-driven decode vectors followed by hand-written handshake,
// stall, flush and reset sequences. Scoreboard expectations follow
// whether Z16_DECODE_SCOREBOARD_EN is defined for the build.
module tb_z16_decode_stage;

`ifdef Z16_DECODE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_instr = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [3:0]  o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr;
    logic [15:0] o_imm;
    logic        o_rd_wen, o_mem_wen;
    logic [3:0]  o_alu_ctrl;
    logic        i_wb_valid = 1'b0;
    logic [3:0]  i_wb_addr = '0;
    logic        i_flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    z16_decode_stage #(.XLEN(16), .SB_CNT_W(1)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_instr    (i_instr),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_opcode   (o_opcode),
        .o_rd_addr  (o_rd_addr),
        .o_rs1_addr (o_rs1_addr),
        .o_rs2_addr (o_rs2_addr),
        .o_imm      (o_imm),
        .o_rd_wen   (o_rd_wen),
        .o_mem_wen  (o_mem_wen),
        .o_alu_ctrl (o_alu_ctrl),
        .i_wb_valid (i_wb_valid),
        .i_wb_addr  (i_wb_addr),
        .i_flush    (i_flush)
    );

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op, rd, rs1, rs2;
        logic [15:0] imm;
        logic        rd_wen, mem_wen;
        logic [3:0]  alu;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Called at posedge+1; async reset pulse well clear of clock edges.
    task automatic do_reset();
        i_valid    = 1'b0;
        i_flush    = 1'b0;
        i_wb_valid = 1'b0;
        i_ready    = 1'b1;
        i_rst      = 1'b1;
        #2;
        i_rst      = 1'b0;
        #1;
    endtask

    task automatic present(input logic [15:0] ins);
        i_instr = ins;
        i_valid = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'hF539, 4'h9, 4'h3, 4'h3, 4'hF, 16'hFFF5, 1'b1, 1'b0, 4'h0};
        vecs[1]  = '{16'h4321, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0000, 1'b1, 1'b0, 4'h1};
        vecs[2]  = '{16'h7A5A, 4'hA, 4'h5, 4'hA, 4'h7, 16'h0007, 1'b1, 1'b0, 4'h0};
        vecs[3]  = '{16'h8C9A, 4'hA, 4'h9, 4'hC, 4'h8, 16'hFFF8, 1'b1, 1'b0, 4'h0};
        vecs[4]  = '{16'h12EB, 4'hB, 4'hE, 4'h2, 4'h1, 16'hFFFE, 1'b0, 1'b1, 4'h0};
        vecs[5]  = '{16'h347B, 4'hB, 4'h7, 4'h4, 4'h3, 16'h0007, 1'b0, 1'b1, 4'h0};
        vecs[6]  = '{16'hABC8, 4'h8, 4'hC, 4'hB, 4'hA, 16'h0000, 1'b1, 1'b0, 4'h8};
        vecs[7]  = '{16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h0};
        vecs[8]  = '{16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 16'h0000, 1'b0, 1'b0, 4'h0};
        vecs[9]  = '{16'h0719, 4'h9, 4'h1, 4'h1, 4'h0, 16'h0007, 1'b1, 1'b0, 4'h0};
        vecs[10] = '{16'h5E4C, 4'hC, 4'h4, 4'hE, 4'h5, 16'h0000, 1'b0, 1'b0, 4'h0};

        // Reset state
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_opcode", o_opcode, 0);
        check("rst_imm", o_imm, 0);
        check("rst_rd_wen", o_rd_wen, 0);
        i_rst = 1'b0;
        #1;
        check("rst_ready", o_ready, 1);

        // Decode table: each vector from a clean reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            present(vecs[i].instr);
            check($sformatf("v%0d_ready", i), o_ready, 1);
            tick();
            i_valid = 1'b0;
            check($sformatf("v%0d_valid", i), o_valid, 1);
            check($sformatf("v%0d_op", i), o_opcode, vecs[i].op);
            check($sformatf("v%0d_rd", i), o_rd_addr, vecs[i].rd);
            check($sformatf("v%0d_rs1", i), o_rs1_addr, vecs[i].rs1);
            check($sformatf("v%0d_rs2", i), o_rs2_addr, vecs[i].rs2);
            check($sformatf("v%0d_imm", i), o_imm, vecs[i].imm);
            check($sformatf("v%0d_rd_wen", i), o_rd_wen, vecs[i].rd_wen);
            check($sformatf("v%0d_mem_wen", i), o_mem_wen, vecs[i].mem_wen);
            check($sformatf("v%0d_alu", i), o_alu_ctrl, vecs[i].alu);
            tick();
            check($sformatf("v%0d_drain", i), o_valid, 0);
        end

        // RAW stall released one cycle after writeback.
        do_reset();
        present(16'h0021);
        check("raw_first_ready", o_ready, 1);
        tick();
        present(16'h0232);
        check("raw_stall0", o_ready, !SB);
        tick();
        check("raw_stall1", o_ready, !SB);
        i_wb_valid = 1'b1;
        i_wb_addr  = 4'h2;
        #1;
        check("raw_wb_same_cycle", o_ready, !SB);
        tick();
        i_wb_valid = 1'b0;
        #1;
        check("raw_released", o_ready, 1);
        tick();
        i_valid = 1'b0;
        check("raw_out_valid", o_valid, 1);
        check("raw_out_rs1", o_rs1_addr, 2);
        check("raw_out_op", o_opcode, 2);

        // Hold for 4 cycles, then back-to-back bundles.
        do_reset();
        i_ready = 1'b0;
        present(16'h4321);
        check("hold_accept", o_ready, 1);
        tick();
        present(16'h5E4C);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("hold%0d_valid", c), o_valid, 1);
            check($sformatf("hold%0d_op", c), o_opcode, 1);
            check($sformatf("hold%0d_rd", c), o_rd_addr, 2);
            check($sformatf("hold%0d_rs1", c), o_rs1_addr, 3);
            check($sformatf("hold%0d_rs2", c), o_rs2_addr, 4);
            check($sformatf("hold%0d_alu", c), o_alu_ctrl, 1);
            check($sformatf("hold%0d_ready", c), o_ready, 0);
            tick();
        end
        i_ready = 1'b1;
        #1;
        check("b2b_ready0", o_ready, 1);
        tick();
        check("b2b_valid0", o_valid, 1);
        check("b2b_op0", o_opcode, 4'hC);
        present(16'hFFFF);
        check("b2b_ready1", o_ready, 1);
        tick();
        check("b2b_valid1", o_valid, 1);
        check("b2b_op1", o_opcode, 4'hF);
        i_valid = 1'b0;
        tick();
        check("b2b_drain", o_valid, 0);

        // Flush of held writer releases its pending count.
        do_reset();
        i_ready = 1'b0;
        present(16'h0073);
        tick();
        present(16'h0703);
        check("fl_held_ready", o_ready, 0);
        i_flush = 1'b1;
        #1;
        check("fl_ready_low", o_ready, 0);
        tick();
        i_flush = 1'b0;
        check("fl_valid_cleared", o_valid, 0);
        #1;
        check("fl_dep_ready", o_ready, 1);
        tick();
        i_valid = 1'b0;
        check("fl_dep_valid", o_valid, 1);
        check("fl_dep_rs1", o_rs1_addr, 7);

        // Saturation with 1-bit counters.
        do_reset();
        present(16'h0051);
        check("sat_first", o_ready, 1);
        tick();
        present(16'h0052);
        check("sat_second_stall", o_ready, !SB);
        tick();
        check("sat_second_stall2", o_ready, !SB);
        i_wb_valid = 1'b1;
        i_wb_addr  = 4'h5;
        #1;
        check("sat_wb_same_cycle", o_ready, !SB);
        tick();
        i_wb_valid = 1'b0;
        #1;
        check("sat_second_go", o_ready, 1);
        tick();
        present(16'h0053);
        check("sat_third_stall", o_ready, !SB);
        i_wb_valid = 1'b1;
        #1;
        tick();
        i_wb_valid = 1'b0;
        #1;
        check("sat_third_go", o_ready, 1);
        tick();
        present(16'h0504);
        check("sat_count_one", o_ready, !SB);
        i_wb_valid = 1'b1;
        #1;
        tick();
        i_wb_valid = 1'b0;
        #1;
        check("sat_reader_go", o_ready, 1);
        tick();
        i_valid = 1'b0;

        // Writeback on an idle register must not underflow.
        do_reset();
        i_wb_valid = 1'b1;
        i_wb_addr  = 4'h6;
        tick();
        i_wb_valid = 1'b0;
        present(16'h0061);
        check("uf_writer_ready", o_ready, 1);
        tick();
        present(16'h0604);
        check("uf_reader_stall", o_ready, !SB);
        i_valid = 1'b0;

        // Accept and writeback on the same register cancel.
        do_reset();
        i_wb_valid = 1'b1;
        i_wb_addr  = 4'h8;
        present(16'h0081);
        check("same_accept", o_ready, 1);
        tick();
        i_wb_valid = 1'b0;
        present(16'h0804);
        check("same_unchanged", o_ready, 1);
        tick();
        i_valid = 1'b0;

        // Reset mid-stall.
        do_reset();
        i_ready = 1'b0;
        present(16'h0091);
        tick();
        i_valid = 1'b0;
        check("mid_held", o_valid, 1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_op", o_opcode, 0);
        check("mid_rst_rd", o_rd_addr, 0);
        i_rst = 1'b0;
        present(16'h0904);
        check("mid_reader_ready", o_ready, 1);
        tick();
        i_valid = 1'b0;
        check("mid_reader_valid", o_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
